// File: rtl/mac_pkg.sv
// Shared types and constants for the streaming multiply-accumulate engine:
// FSM state encoding and the saturation bounds as functions of accumulator width.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Largest signed value representable in acc_w bits.
  function automatic logic signed [63:0] sat_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  // Smallest signed value representable in acc_w bits.
  function automatic logic signed [63:0] sat_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/mac_mul_stage.sv
// Registered signed DATA_W x DATA_W multiplier with a valid bit that follows
// its input by one cycle. Synchronous active-low reset clears only the valid bit.
module mac_mul_stage #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   prod,
  output logic                  prod_valid
);

  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;

  assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) prod_valid <= 1'b0;
    else        prod_valid <= in_valid;
  end

  // NOTE: the product register is left unreset; prod_valid qualifies it, so its content after reset is never used.
  always_ff @(posedge clk) begin
    if (in_valid) prod <= a_ext * b_ext;
  end

endmodule

// File: rtl/mac_stream.sv
// Sequential multiply-accumulate engine: start with a bias, stream N_TERMS signed
// pairs, return the sum. Define MAC_STREAM_SAT_EN for saturating accumulation.
module mac_stream
  import mac_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int N_TERMS = 3,
  parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ACC_W-1:0]  bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              overflow,
  output logic              busy
);

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic [ACC_W-1:0]    prod_ext;
  logic [2*DATA_W-1:0] prod;
  logic                prod_valid;
  logic                accept;

  assign in_ready = (state == RUN) && (count < CNT_W'(N_TERMS));
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign result   = acc;
  assign prod_ext = ACC_W'($signed(prod));

  mac_mul_stage #(.DATA_W(DATA_W)) u_mul (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (accept),
    .a          (in_data),
    .b          (in_weight),
    .prod       (prod),
    .prod_valid (prod_valid)
  );

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
`ifdef MAC_STREAM_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

  logic [ACC_W:0] sum_wide;
  logic           ovf_step;
  logic           ovf_q;

  // One guard bit: differing top two bits of the sum mean signed overflow.
  always_comb begin
    ovf_step = 1'b0;
    sum_wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
    acc_next = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      ovf_step = 1'b1;
      acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  assign overflow = ovf_q;
`else
  always_comb begin
    acc_next = acc + prod_ext;
  end

  assign overflow = 1'b0;
`endif

  // The accumulate runs off the multiply stage's valid bit, so it covers RUN and DRAIN alike.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
`ifdef MAC_STREAM_SAT_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      if (prod_valid) begin
        acc   <= acc_next;
`ifdef MAC_STREAM_SAT_EN
        ovf_q <= ovf_q | ovf_step;
`endif
      end
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= bias;
            count <= '0;
            state <= RUN;
`ifdef MAC_STREAM_SAT_EN
            ovf_q <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (accept) begin
            count <= count + 1'b1;
            if (count == CNT_W'(N_TERMS - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_stream.sv
// Scoreboard bench for mac_stream: directed cases plus randomized jobs checked
// against an arithmetic reference model; a monitor checks each output handshake.
module tb_mac_stream;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 16;
  localparam int N_TERMS = 3;
  localparam int CNT_W   = $clog2(N_TERMS + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ACC_W-1:0]  bias;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_weight;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;
  logic              overflow;
  logic              busy;

  typedef struct packed {
    logic [ACC_W-1:0] res;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   c0;
  int   job_d[N_TERMS];
  int   job_w[N_TERMS];

  mac_stream #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .N_TERMS (N_TERMS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_weight (in_weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: bias plus the sum of products, clamped per step when saturating.
  function automatic exp_t model(input int b);
    longint a = b;
    exp_t   e;
    e.ovf = 1'b0;
    for (int i = 0; i < N_TERMS; i++) begin
      a = a + longint'(job_d[i]) * longint'(job_w[i]);
`ifdef MAC_STREAM_SAT_EN
      if (a > (64'sd1 <<< (ACC_W - 1)) - 1) begin
        a = (64'sd1 <<< (ACC_W - 1)) - 1;
        e.ovf = 1'b1;
      end else if (a < -(64'sd1 <<< (ACC_W - 1))) begin
        a = -(64'sd1 <<< (ACC_W - 1));
        e.ovf = 1'b1;
      end
`endif
    end
    e.res = a[ACC_W-1:0];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int b);
    bias  = ACC_W'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_pair(input int d, input int w);
    int n = 0;
    in_valid  = 1'b1;
    in_data   = DATA_W'(d);
    in_weight = DATA_W'(w);
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("out_valid_wait", out_valid, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_hs", busy, 0);
  endtask

  task automatic set_job(input int d0, input int w0, input int d1, input int w1,
                         input int d2, input int w2);
    job_d[0] = d0; job_w[0] = w0;
    job_d[1] = d1; job_w[1] = w1;
    job_d[2] = d2; job_w[2] = w2;
  endtask

  task automatic run_job(input int b, input int gap_max, input int hold);
    exp_t e = model(b);
    exp_q.push_back(e);
    do_start(b);
    for (int i = 0; i < N_TERMS; i++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      send_pair(job_d[i], job_w[i]);
    end
    wait_out();
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_result", result, e.res);
      tick();
    end
    handshake();
  endtask

  // Monitor: every output handshake pops one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", out_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", result, mon_e.res);
          check("overflow", overflow, mon_e.ovf);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_weight = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick();

    // Latency with in_valid held high: out_valid in cycle N_TERMS+2.
    set_job(5, 2, 7, 2, 9, 2);
    exp_q.push_back(model(0));
    c0 = cyc;
    do_start(0);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < N_TERMS; i++) send_pair(job_d[i], job_w[i]);
    wait_out();
    check("latency", cyc - c0, N_TERMS + 2);
    check("result_42", result, 42);
    handshake();

    // Negative operands with bias.
    set_job(-3, 4, 2, -5, 1, 1);
    run_job(10, 0, 0);

    // in_valid pattern 1,0,0,1,0,1.
    set_job(1, 1, 2, 2, 3, 3);
    exp_q.push_back(model(0));
    do_start(0);
    send_pair(1, 1);
    repeat (2) tick();
    send_pair(2, 2);
    tick();
    send_pair(3, 3);
    check("in_ready_after_last", in_ready, 0);
    wait_out();
    check("result_14", result, 14);
    handshake();

    // Output held for 10 cycles with start pulses that must be ignored.
    set_job(4, -6, 11, 3, -2, -8);
    exp_q.push_back(model(100));
    do_start(100);
    for (int i = 0; i < N_TERMS; i++) send_pair(job_d[i], job_w[i]);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      bias  = 16'h1234;
      check("stall_valid", out_valid, 1);
      check("stall_result", result, 16'(100 - 24 + 33 + 16));
      tick();
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    check("hs_start_ignored", busy, 0);
    check("hs_out_valid_low", out_valid, 0);

    // Overflow case: 3 * 127 * 127 = 48387.
    set_job(127, 127, 127, 127, 127, 127);
    run_job(0, 1, 2);
`ifdef MAC_STREAM_SAT_EN
    check("sat_expect", model(0).res, 16'h7FFF);
`else
    check("wrap_expect", model(0).res, 16'hBD03);
`endif

    // Reset after the second accepted pair discards the partial sum.
    set_job(20, 3, 30, 3, 40, 3);
    do_start(7);
    send_pair(job_d[0], job_w[0]);
    send_pair(job_d[1], job_w[1]);
    reset = 1'b0;
    tick();
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_busy", busy, 0);
    reset = 1'b1;
    tick();
    set_job(1, 1, 1, 1, 1, 1);
    run_job(0, 0, 0);

    // Randomized jobs with random gaps and output stalls.
    for (int j = 0; j < 24; j++) begin
      for (int i = 0; i < N_TERMS; i++) begin
        job_d[i] = int'($signed(DATA_W'($urandom)));
        job_w[i] = int'($signed(DATA_W'($urandom)));
      end
      run_job(int'($signed(ACC_W'($urandom))), 2, int'($urandom_range(3, 0)));
      repeat ($urandom_range(2, 0)) tick();
    end

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
